// File: rtl/lane_reg_bank_if.sv
// -----------------------------------------------------------------------------
// lane_reg_bank_if
//   Bus bundle for lane_reg_bank: one lane-masked write port, one registered
//   read port, one dirty-flag acknowledge port and the per-entry dirty vector.
//
//   Parameters : WIDTH (entry width), LANES (lanes per entry), DEPTH (entries)
//   Signals    : wr_en, wr_addr[AW], wr_lanes[LANES], wr_op[2], wr_data[WIDTH]
//                rd_addr[AW], rd_data[WIDTH]
//                ack_en, ack_addr[AW], dirty[DEPTH]
//   Modports   : master - drives requests, observes rd_data / dirty
//                slave  - the register bank itself
// -----------------------------------------------------------------------------
interface lane_reg_bank_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int DEPTH = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [LANES-1:0]  wr_lanes;
    logic [1:0]        wr_op;
    logic [WIDTH-1:0]  wr_data;

    logic [AW-1:0]     rd_addr;
    logic [WIDTH-1:0]  rd_data;

    logic              ack_en;
    logic [AW-1:0]     ack_addr;
    logic [DEPTH-1:0]  dirty;

    modport master (
        output wr_en, wr_addr, wr_lanes, wr_op, wr_data,
        output rd_addr,
        output ack_en, ack_addr,
        input  rd_data, dirty
    );

    modport slave (
        input  wr_en, wr_addr, wr_lanes, wr_op, wr_data,
        input  rd_addr,
        input  ack_en, ack_addr,
        output rd_data, dirty
    );
endinterface

// File: rtl/lane_reg_bank.sv
// -----------------------------------------------------------------------------
// lane_reg_bank
//   DEPTH x WIDTH register bank whose entries are split into LANES equal lanes.
//   Each write names an entry, a lane mask and an operation:
//     00 load       masked lanes take the same lane of wr_data
//     01 shift-up   lane i takes old lane i-1, lane 0 takes zero
//     10 rotate-up  as shift-up, but lane 0 takes old lane LANES-1
//     11 lane-clear masked lanes become zero
//   Unmasked lanes always hold. A per-entry dirty flag is set by every accepted
//   write and cleared by an acknowledge; a write to the same entry in the same
//   cycle as its acknowledge wins.
//
//   Ports:
//     clk      in   rising-edge clock
//     clear_n  in   asynchronous active-low reset; zeroes storage, rd_data, dirty
//     bus      slave modport of lane_reg_bank_if (write/read/ack/dirty)
//
//   Read data is registered (latency 1) and returns the pre-write value when
//   the read and a write target the same entry in one cycle. Out-of-range
//   addresses are ignored for writes and acknowledges and read back as zero.
// -----------------------------------------------------------------------------
module lane_reg_bank #(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            clear_n,
    lane_reg_bank_if.slave  bus
);
    localparam int LW = WIDTH / LANES;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One bit wider than the address so that DEPTH itself is representable
    // and the range compare never degenerates for non-power-of-two depths.
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    // Lanes must tile the entry exactly and there must be something to shift.
    generate
        if ((LANES < 2) || ((WIDTH % LANES) != 0)) begin : g_bad_params
            $error("lane_reg_bank: WIDTH must be a multiple of LANES and LANES >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SHIFT  = 2'b01,
        OP_ROTATE = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic [DEPTH-1:0] dirty_q;

    // -------------------------------------------------------------------------
    // Request qualification
    // -------------------------------------------------------------------------
    logic wr_in_range;
    logic rd_in_range;
    logic ack_in_range;
    logic wr_hit;
    logic ack_hit;

    assign wr_in_range  = ({1'b0, bus.wr_addr}  < DEPTH_L);
    assign rd_in_range  = ({1'b0, bus.rd_addr}  < DEPTH_L);
    assign ack_in_range = ({1'b0, bus.ack_addr} < DEPTH_L);

    // An empty lane mask or an out-of-range entry makes the write a no-op,
    // including for the dirty flag.
    assign wr_hit  = bus.wr_en && (|bus.wr_lanes) && wr_in_range;
    assign ack_hit = bus.ack_en && ack_in_range;

    // -------------------------------------------------------------------------
    // Write datapath: build the full-width candidate for the selected operation,
    // then merge it with the old entry under the expanded lane mask.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_cand;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] wr_new;

    // NOTE: every signal written in an always_comb gets a default on entry so
    // that no path through the block can leave it holding (which would infer a
    // latch).
    always_comb begin
        wr_old = '0;
        if (wr_in_range) begin
            wr_old = mem[bus.wr_addr];
        end
    end

    always_comb begin
        wr_cand = '0;
        unique case (op_e'(bus.wr_op))
            OP_LOAD:   wr_cand = bus.wr_data;
            OP_SHIFT:  wr_cand = {wr_old[WIDTH-LW-1:0], {LW{1'b0}}};
            OP_ROTATE: wr_cand = {wr_old[WIDTH-LW-1:0], wr_old[WIDTH-1 -: LW]};
            OP_CLEAR:  wr_cand = '0;
            default:   wr_cand = '0;
        endcase
    end

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i*LW +: LW] = {LW{bus.wr_lanes[i]}};
        end
    end

    assign wr_new = (wr_cand & lane_mask) | (wr_old & ~lane_mask);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the array is reset along with the rest of the state because a
    // cleared bank must read back zero immediately; this keeps it in flops
    // rather than letting it map onto a RAM macro. Sequential state uses
    // non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else if (wr_hit) begin
            mem[bus.wr_addr] <= wr_new;
        end
    end

    // -------------------------------------------------------------------------
    // Read port: sampled from the pre-edge array, which gives read-before-write
    // behaviour for a same-cycle write to the same entry.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rd_q <= '0;
        end else if (rd_in_range) begin
            rd_q <= mem[bus.rd_addr];
        end else begin
            rd_q <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Dirty flags: the acknowledge clear is applied first and the write set
    // second, so a collision on one entry leaves it dirty.
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0] dirty_next;

    always_comb begin
        dirty_next = dirty_q;
        if (ack_hit) begin
            dirty_next[bus.ack_addr] = 1'b0;
        end
        if (wr_hit) begin
            dirty_next[bus.wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            dirty_q <= '0;
        end else begin
            dirty_q <= dirty_next;
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.dirty   = dirty_q;

endmodule

// File: tb/tb_lane_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_lane_reg_bank
//   Directed and randomized stimulus for lane_reg_bank. A lane-level reference
//   model (each entry held as an array of lane values, operations expressed as
//   moves between lanes) predicts rd_data and dirty after every clock edge.
// -----------------------------------------------------------------------------
module tb_lane_reg_bank;
    localparam int W  = 16;
    localparam int L  = 2;
    localparam int D  = 4;
    localparam int LW = W / L;
    localparam int AW = (D > 1) ? $clog2(D) : 1;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHIFT  = 2'b01;
    localparam logic [1:0] OP_ROTATE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    logic clk;
    logic clear_n;

    lane_reg_bank_if #(.WIDTH(W), .LANES(L), .DEPTH(D)) bus ();

    lane_reg_bank #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    logic [LW-1:0] m_lane [D][L];
    logic [D-1:0]  m_dirty;
    logic [W-1:0]  exp_rd;

    function automatic logic [W-1:0] m_entry(input int a);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) v[i*LW +: LW] = m_lane[a][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < D; a++)
            for (int i = 0; i < L; i++) m_lane[a][i] = '0;
        m_dirty = '0;
        exp_rd  = '0;
    endtask

    // Applies one clock edge worth of requests to the model.
    task automatic model_edge();
        int wa, ra, aa;
        logic [LW-1:0] old [L];
        logic [LW-1:0] val;
        logic [W-1:0]  d;
        wa = int'(bus.wr_addr);
        ra = int'(bus.rd_addr);
        aa = int'(bus.ack_addr);
        d  = bus.wr_data;
        exp_rd = (ra < D) ? m_entry(ra) : '0;
        if (bus.ack_en && aa < D) m_dirty[aa] = 1'b0;
        if (bus.wr_en && bus.wr_lanes != '0 && wa < D) begin
            for (int i = 0; i < L; i++) old[i] = m_lane[wa][i];
            for (int i = 0; i < L; i++) begin
                case (bus.wr_op)
                    OP_LOAD:   val = d[i*LW +: LW];
                    OP_SHIFT:  val = (i == 0) ? '0 : old[i-1];
                    OP_ROTATE: val = old[(i + L - 1) % L];
                    default:   val = '0;
                endcase
                if (bus.wr_lanes[i]) m_lane[wa][i] = val;
            end
            m_dirty[wa] = 1'b1;
        end
    endtask

    // ---------------------------------------------------------------------
    // Checking helpers
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input int wa, input logic [L-1:0] lanes,
                         input logic [1:0] op, input logic [W-1:0] d, input int ra,
                         input logic ack, input int aa);
        bus.wr_en    = we;
        bus.wr_addr  = AW'(wa);
        bus.wr_lanes = lanes;
        bus.wr_op    = op;
        bus.wr_data  = d;
        bus.rd_addr  = AW'(ra);
        bus.ack_en   = ack;
        bus.ack_addr = AW'(aa);
    endtask

    // One clock: model advances at the edge, outputs sampled 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".rd"},    32'(bus.rd_data), 32'(exp_rd));
        check({tag, ".dirty"}, 32'(bus.dirty),   32'(m_dirty));
    endtask

    task automatic idle_read(input int ra, input string tag);
        drive(1'b0, 0, '0, OP_LOAD, '0, ra, 1'b0, 0);
        cycle(tag);
    endtask

    task automatic load(input int wa, input logic [L-1:0] lanes, input logic [W-1:0] d, input string tag);
        drive(1'b1, wa, lanes, OP_LOAD, d, wa, 1'b0, 0);
        cycle(tag);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        drive(1'b0, 0, '0, OP_LOAD, '0, 0, 1'b0, 0);
        model_reset();
        clear_n = 1'b0;
        #12;
        check("reset.rd",    32'(bus.rd_data), 32'h0);
        check("reset.dirty", 32'(bus.dirty),   32'h0);
        @(negedge clk);
        clear_n = 1'b1;

        // Masked load into entry 0: only the upper lane changes.
        load(0, 2'b10, 16'hABCD, "mload.wr");
        idle_read(0, "mload.rd");
        check("mload.value", 32'(bus.rd_data),  32'h0000AB00);
        check("mload.dirty0", 32'(bus.dirty[0]), 32'h1);
        drive(1'b0, 0, '0, OP_LOAD, '0, 0, 1'b1, 0);
        cycle("mload.ack");
        load(0, 2'b00, 16'hABCD, "mload.empty");
        idle_read(0, "mload.rd2");
        check("mload.hold",   32'(bus.rd_data),  32'h0000AB00);
        check("mload.nodirty", 32'(bus.dirty[0]), 32'h0);

        // Shift / rotate on entry 1.
        load(1, 2'b11, 16'h1234, "shift.init");
        drive(1'b1, 1, 2'b11, OP_SHIFT, '0, 1, 1'b0, 0);
        cycle("shift.op");
        idle_read(1, "shift.rd");
        check("shift.value", 32'(bus.rd_data), 32'h00003400);

        load(1, 2'b11, 16'h1234, "rot.init");
        drive(1'b1, 1, 2'b11, OP_ROTATE, '0, 1, 1'b0, 0);
        cycle("rot.op");
        idle_read(1, "rot.rd");
        check("rot.value", 32'(bus.rd_data), 32'h00003412);

        load(1, 2'b11, 16'h1234, "rotm.init");
        drive(1'b1, 1, 2'b01, OP_ROTATE, '0, 1, 1'b0, 0);
        cycle("rotm.op");
        idle_read(1, "rotm.rd");
        check("rotm.value", 32'(bus.rd_data), 32'h00001212);

        // Lane-clear of the lower lane.
        drive(1'b1, 1, 2'b01, OP_CLEAR, 16'hFFFF, 1, 1'b0, 0);
        cycle("lclr.op");
        idle_read(1, "lclr.rd");
        check("lclr.value", 32'(bus.rd_data), 32'h00001200);

        // Read during write returns the old contents.
        load(2, 2'b11, 16'h5555, "rdw.init");
        load(2, 2'b11, 16'hAAAA, "rdw.wr");
        check("rdw.old", 32'(bus.rd_data), 32'h00005555);
        idle_read(2, "rdw.rd");
        check("rdw.new", 32'(bus.rd_data), 32'h0000AAAA);

        // Dirty collisions.
        drive(1'b1, 3, 2'b11, OP_LOAD, 16'h0F0F, 3, 1'b1, 3);
        cycle("dcol.same");
        check("dcol.same3", 32'(bus.dirty[3]), 32'h1);
        drive(1'b0, 0, '0, OP_LOAD, '0, 3, 1'b1, 3);
        cycle("dcol.ack");
        check("dcol.ack3", 32'(bus.dirty[3]), 32'h0);
        drive(1'b0, 0, '0, OP_LOAD, '0, 0, 1'b1, 0);
        cycle("dcol.ack0");
        drive(1'b1, 3, 2'b11, OP_LOAD, 16'h1111, 0, 1'b0, 0);
        cycle("dcol.set3");
        drive(1'b1, 0, 2'b01, OP_LOAD, 16'h00EE, 0, 1'b1, 3);
        cycle("dcol.diff");
        check("dcol.diff0", 32'(bus.dirty[0]), 32'h1);
        check("dcol.diff3", 32'(bus.dirty[3]), 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, D - 1),
                  L'($urandom), 2'($urandom), W'($urandom),
                  $urandom_range(0, D - 1), ($urandom_range(0, 2) == 0),
                  $urandom_range(0, D - 1));
            cycle("rand");
        end

        // Asynchronous reset between edges with a write pending.
        load(1, 2'b11, 16'hBEEF, "arst.prep");
        check("arst.prep_dirty_nz", 32'(bus.dirty != '0), 32'h1);
        @(negedge clk);
        drive(1'b1, 1, 2'b11, OP_LOAD, 16'hFFFF, 1, 1'b1, 2);
        #2;
        clear_n = 1'b0;
        #1;
        check("arst.rd",    32'(bus.rd_data), 32'h0);
        check("arst.dirty", 32'(bus.dirty),   32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("arst.hold_rd",    32'(bus.rd_data), 32'h0);
        check("arst.hold_dirty", 32'(bus.dirty),   32'h0);
        @(negedge clk);
        clear_n = 1'b1;
        drive(1'b1, 2, 2'b11, OP_LOAD, 16'hC3C3, 1, 1'b0, 0);
        cycle("arst.first");
        check("arst.first_dirty", 32'(bus.dirty), 32'h4);
        for (int a = 0; a < D; a++) idle_read(a, "arst.scan");
        check("arst.entry3", 32'(bus.rd_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_reg_bank.md
LANE_REG_BANK -- requirements
Module: lane_reg_bank

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, entry width in bits; LANES, default 2, independently writable lanes per entry; DEPTH, default 4, number of entries.
REQ-002 Derived SHALL be: LW = WIDTH/LANES; AW = max(1, clog2(DEPTH)); WIDTH not divisible by LANES, or LANES < 2, SHALL be an elaboration error.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 clear_n  in  1  asynchronous active-low reset.
REQ-006 wr_en  in  1  write-port operation request.
REQ-007 wr_addr  in  AW  target entry.
REQ-008 wr_lanes  in  LANES  lane mask; bit i selects bits [i*LW +: LW].
REQ-009 wr_op  in  2  00 load, 01 shift-up, 10 rotate-up, 11 lane-clear.
REQ-010 wr_data  in  WIDTH  load data.
REQ-011 rd_addr  in  AW  read entry.
REQ-012 rd_data  out  WIDTH  registered read data.
REQ-013 ack_en  in  1  clear dirty flag of ack_addr.
REQ-014 ack_addr  in  AW  entry to acknowledge.
REQ-015 dirty  out  DEPTH  per-entry modified flag, registered.

Function
REQ-016 Storage SHALL be DEPTH x WIDTH flops; every write is masked per lane; unmasked lanes SHALL hold.
REQ-017 Load SHALL set each masked lane to the same lane of wr_data.
REQ-018 Shift-up SHALL compute the entry shifted left by LW with zero fill (lane i takes old lane i-1, lane 0 takes 0), then update only masked lanes.
REQ-019 Rotate-up SHALL behave as shift-up, except lane 0 takes the old lane LANES-1.
REQ-020 Lane-clear SHALL set masked lanes to 0.
REQ-021 A write SHALL take effect at the rising edge where wr_en=1; storage is visible to a read issued on the next cycle.
REQ-022 A write SHALL be ignored (no storage or dirty change) for any of:
- wr_lanes all zero;
- wr_addr >= DEPTH.
REQ-023 rd_data SHALL register storage[rd_addr] every cycle (latency 1).
- When rd_addr equals a same-cycle wr_addr, rd_data SHALL return the pre-write value.
- rd_addr >= DEPTH SHALL return 0.
REQ-024 dirty[a] SHALL set on any non-ignored write to entry a.
REQ-025 dirty[a] SHALL clear on ack_en with ack_addr=a; ack_addr >= DEPTH SHALL be ignored.
REQ-026 A simultaneous write and ack to the same entry SHALL leave dirty=1 (write wins); to different entries, both SHALL take effect.

Reset
REQ-027 clear_n=0 SHALL immediately, without a clock edge, force all storage, rd_data and dirty to 0.
REQ-028 While clear_n=0, all inputs SHALL be ignored.
REQ-029 After clear_n deasserts, the first operation SHALL be accepted at the next rising edge.
REQ-030 Reset asserted mid-operation SHALL discard any write in that cycle.

Verification
REQ-031 Reset: storage and dirty both nonzero; clear_n low between edges -> rd_data=0x0000 and dirty=4'b0000 before the next edge.
REQ-032 Masked load: entry0=0x0000; load 0xABCD with wr_lanes=2'b10 -> next-cycle read 0xAB00, dirty[0]=1; repeat with wr_lanes=2'b00 -> unchanged, no dirty change.
REQ-033 Shift/rotate:
- entry1=0x1234; shift-up with lanes 2'b11 -> 0x3400;
- reload 0x1234; rotate-up with lanes 2'b11 -> 0x3412;
- reload 0x1234; rotate-up with lanes 2'b01 -> 0x1212.
REQ-034 Read-during-write: entry2=0x5555; same cycle load 0xAAAA to entry 2 and rd_addr=2 -> rd_data 0x5555, next cycle 0xAAAA.
REQ-035 Dirty collision:
- write and ack entry3 in the same cycle -> dirty[3]=1;
- ack alone -> dirty[3]=0;
- write entry0 with ack entry3 -> dirty[0]=1, dirty[3]=0.
